// File: rtl/aes_inv_cipher_if.sv
// Handshake/data bundle for aes_inv_cipher: start/key_valid/round_keys in, data_out/busy/done back.
interface aes_inv_cipher_if #(
    parameter int Nr = 10
);
    logic                    start;
    logic [127:0]            data_in;
    logic                    key_valid;
    logic [(Nr+1)*128-1:0]   round_keys;
    logic [127:0]            data_out;
    logic                    busy;
    logic                    done;

    modport master (
        output start, data_in, key_valid, round_keys,
        input  data_out, busy, done
    );

    modport slave (
        input  start, data_in, key_valid, round_keys,
        output data_out, busy, done
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES InvCipher, one round per clock, AES-128/192/256 by parameter.
// Optional AES_DEC_ZEROIZE_EN: clears the state register at FINAL and data_out on accept.
module aes_inv_cipher #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    aes_inv_cipher_if.slave  bus
);

    localparam int RW = $clog2(Nr + 1);

    if (Nr != Nk + 6) begin : g_cfg_check
        $error("aes_inv_cipher: Nr must equal Nk+6");
    end

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    fsm_t            fsm;
    logic [127:0]    state;
    logic [RW-1:0]   rnd;
    logic [127:0]    data_out_q;
    logic            busy_q;
    logic            done_q;

    logic [127:0]    rk_cur;
    logic [127:0]    key_add;
    logic [127:0]    round_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        // column c of row r takes the byte from column c-r (right rotation)
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127-32*c-8*r -: 8] = s[127-32*((c+4-r)%4)-8*r -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = INV_SBOX[2047-8*int'(s[127-8*i -: 8]) -: 8];
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // In FINAL rnd is 0, so the same key-add path produces the plaintext.
    always_comb begin
        rk_cur    = bus.round_keys[(Nr - int'(rnd))*128 +: 128];
        key_add   = inv_sub_bytes(inv_shift_rows(state)) ^ rk_cur;
        round_out = inv_mix_columns(key_add);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            state      <= '0;
            rnd        <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (bus.start && bus.key_valid) begin
                        state  <= bus.data_in ^ bus.round_keys[127:0];
                        rnd    <= RW'(Nr - 1);
                        busy_q <= 1'b1;
                        fsm    <= (Nr == 1) ? FINAL : ROUND;
`ifdef AES_DEC_ZEROIZE_EN
                        data_out_q <= '0;
`endif
                    end
                end
                ROUND: begin
                    state <= round_out;
                    rnd   <= rnd - RW'(1);
                    if (rnd == RW'(1)) fsm <= FINAL;
                end
                FINAL: begin
                    data_out_q <= key_add;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    fsm        <= IDLE;
`ifdef AES_DEC_ZEROIZE_EN
                    state      <= '0;
`endif
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher (AES-128 and AES-256 instances) with a result scoreboard.
module tb_aes_inv_cipher;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_inv_cipher_if #(.Nr(10)) b128 ();
    aes_inv_cipher_if #(.Nr(14)) b256 ();

    aes_inv_cipher #(.Nk(4), .Nr(10)) dut128 (.clk(clk), .rst(rst), .bus(b128));
    aes_inv_cipher #(.Nk(8), .Nr(14)) dut256 (.clk(clk), .rst(rst), .bus(b256));

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [127:0] q128 [$];
    logic [127:0] q256 [$];
    logic [7:0]   sbox_t [256];

    localparam logic [255:0] K1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K2   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = '0;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Round key r lands at [1919-128r -: 128]; AES-128 uses the top 1408 bits.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] o;
        int            total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        o = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) o[1919-32*i -: 32] = w[i];
        return o;
    endfunction

    task automatic load_key128(input logic [255:0] key);
        logic [1919:0] full;
        full = expand(key, 4);
        b128.round_keys = full[1919 -: 1408];
    endtask

    task automatic run128(input logic [127:0] ct, input logic [127:0] pt, input int pulse_at, input string tag);
        int n;
        @(negedge clk);
        b128.data_in = ct;
        b128.start   = 1'b1;
        q128.push_back(pt);
        @(posedge clk); #1;
        b128.start = 1'b0;
        n = 1;
        check({tag, "_busy"}, 128'(b128.busy), 128'd1);
        while (!b128.done && n < 60) begin
            if (n == pulse_at) begin
                b128.start   = 1'b1;
                b128.data_in = ~ct;
            end else begin
                b128.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        b128.start = 1'b0;
        check({tag, "_latency"}, 128'(n), 128'd11);
    endtask

    // Scoreboard: each done pops the oldest expected plaintext.
    always @(posedge clk) begin
        #1;
        if (b128.done) check("data_out128", b128.data_out, (q128.size() != 0) ? q128.pop_front() : 'x);
        if (b256.done) check("data_out256", b256.data_out, (q256.size() != 0) ? q256.pop_front() : 'x);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        logic [127:0]  gap_exp;
        logic [1919:0] full;

        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

        rst = 1'b1;
        b128.start = 1'b0; b128.key_valid = 1'b0; b128.data_in = '0; b128.round_keys = '0;
        b256.start = 1'b0; b256.key_valid = 1'b0; b256.data_in = '0; b256.round_keys = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy128",  128'(b128.busy), 128'd0);
        check("rst_done128",  128'(b128.done), 128'd0);
        check("rst_data128",  b128.data_out,   128'd0);
        check("rst_busy256",  128'(b256.busy), 128'd0);
        check("rst_done256",  128'(b256.done), 128'd0);
        check("rst_data256",  b256.data_out,   128'd0);
        @(negedge clk);
        rst = 1'b0;

        load_key128(K1);
        b128.key_valid = 1'b1;
        full = expand(K256, 8);
        b256.round_keys = full;
        b256.key_valid  = 1'b1;

        run128(C1, P1, 0, "aes128_c1");
        load_key128(K2);
        run128(C2, P2, 0, "aes128_b");

        @(negedge clk);
        b256.data_in = C3;
        b256.start   = 1'b1;
        q256.push_back(P1);
        @(posedge clk); #1;
        b256.start = 1'b0;
        n = 1;
        check("aes256_busy", 128'(b256.busy), 128'd1);
        while (!b256.done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("aes256_latency", 128'(n), 128'd15);

        // start without key_valid must be dropped, not queued
        @(negedge clk);
        b128.key_valid = 1'b0;
        b128.data_in   = C2;
        b128.start     = 1'b1;
        @(posedge clk); #1;
        check("nokey_busy", 128'(b128.busy), 128'd0);
        check("nokey_done", 128'(b128.done), 128'd0);
        @(negedge clk);
        b128.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("nokey_busy_later", 128'(b128.busy), 128'd0);
        b128.key_valid = 1'b1;

        load_key128(K1);
        run128(C1, P1, 4, "midstart");

        @(negedge clk);
        b128.data_in = C1;
        b128.start   = 1'b1;
        @(posedge clk); #1;
        b128.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 128'(b128.busy), 128'd0);
        check("abort_done", 128'(b128.done), 128'd0);
        check("abort_data", b128.data_out,   128'd0);
        run128(C1, P1, 0, "after_rst");

        // start held high straight across done
`ifdef AES_DEC_ZEROIZE_EN
        gap_exp = '0;
`else
        gap_exp = P1;
`endif
        @(negedge clk);
        b128.data_in = C1;
        b128.start   = 1'b1;
        q128.push_back(P1);
        q128.push_back(P1);
        @(posedge clk); #1;
        n = 1;
        while (!b128.done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_latency", 128'(n), 128'd11);
        @(posedge clk); #1;
        b128.start = 1'b0;
        check("b2b_busy", 128'(b128.busy), 128'd1);
        check("b2b_gap_data", b128.data_out, gap_exp);
        n = 1;
        while (!b128.done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_second_latency", 128'(n), 128'd11);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
